fsmc_bridge: RTL and testbench

// - Front-end bridge between the MCU FSMC asynchronous SRAM-style port and the

---
 rtl/fsmc_bridge_if.sv | 29 ++
 rtl/fsmc_bridge.sv | 218 +++++++++++++++++++++
 tb/tb_fsmc_bridge.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fsmc_bridge_if.sv
// FSMC pad signals and internal register-bus signals seen by fsmc_bridge.
// The master modport is the environment (MCU pads plus register-bus read mux).
// The slave modport is the bridge itself.
interface fsmc_bridge_if;
    logic        fsmc_ne;
    logic        fsmc_noe;
    logic        fsmc_nwe;
    logic [1:0]  fsmc_nbl;
    logic [15:0] fsmc_a;
    logic [15:0] fsmc_d_in;
    logic [15:0] fsmc_d_out;
    logic        fsmc_d_oe;
    logic [15:0] rdaddr;
    logic [15:0] wraddr;
    logic [1:0]  be;
    logic        write;
    logic [15:0] wrdata;
    logic [15:0] rddata;

    modport master (
        output fsmc_ne, fsmc_noe, fsmc_nwe, fsmc_nbl, fsmc_a, fsmc_d_in, rddata,
        input  fsmc_d_out, fsmc_d_oe, rdaddr, wraddr, be, write, wrdata
    );

    modport slave (
        input  fsmc_ne, fsmc_noe, fsmc_nwe, fsmc_nbl, fsmc_a, fsmc_d_in, rddata,
        output fsmc_d_out, fsmc_d_oe, rdaddr, wraddr, be, write, wrdata
    );
endinterface

// File: rtl/fsmc_bridge.sv
// FSMC asynchronous SRAM-port to clk-domain register-bus bridge.
// Strobes are synchronised, each write strobe becomes one write pulse and
// each read strobe becomes an rdaddr presentation plus registered read return.
// Optional feature macro: FSMC_TIMEOUT_EN (strobe-low watchdog that aborts
// the transaction, flags err and waits for NE high before accepting more).
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | waiting for a strobe; flags noe+nwe overlap as an error
// WR_ACT    | write strobe low; tracking address/data/byte lanes
// WR_COMMIT | write strobe released; write pulse is issued next cycle
// RD_WAIT   | rdaddr presented; counting down the register-bus latency
// RD_HOLD   | read data captured and driven until noe or ne goes high
module fsmc_bridge #(
    parameter int SYNC_STAGES    = 2,
    parameter int RD_LAT         = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic         clk,
    input  logic         sclr_n,
    fsmc_bridge_if.slave bus,
    output logic         busy,
    output logic         err
);

    localparam int RCW = (RD_LAT > 0) ? $clog2(RD_LAT + 1) : 1;

    if (SYNC_STAGES < 2 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_param_check
        $error("fsmc_bridge: SYNC_STAGES must be >= 2 and TIMEOUT_CYCLES within 1..255");
    end

    typedef enum logic [2:0] {
        IDLE,
        WR_ACT,
        WR_COMMIT,
        RD_WAIT,
        RD_HOLD
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] ne_sync, noe_sync, nwe_sync;
    logic ne_s, noe_s, nwe_s;
    logic [15:0] a_r, d_r;
    logic [1:0]  nbl_r;

    logic [15:0] rdaddr_q, rdaddr_nxt;
    logic [15:0] wraddr_q, wraddr_nxt;
    logic [15:0] wrdata_q, wrdata_nxt;
    logic [15:0] d_out_q, d_out_nxt;
    logic [1:0]  be_q, be_nxt;
    logic        write_q, write_nxt;
    logic        oe_q, oe_nxt;
    logic        err_q, err_nxt;
    logic [RCW-1:0] rd_cnt_q, rd_cnt_nxt;
    logic        start_ok;

`ifdef FSMC_TIMEOUT_EN
    logic [7:0] tmo_cnt_q, tmo_cnt_nxt;
    logic       ne_wait_q, ne_wait_nxt;

    // After a timeout abort, no new transaction until the MCU deselects.
    assign start_ok = ~ne_wait_q;
`else
    // Without the watchdog a stuck strobe simply holds the FSM.
    assign start_ok = 1'b1;
`endif

    assign ne_s  = ne_sync[SYNC_STAGES-1];
    assign noe_s = noe_sync[SYNC_STAGES-1];
    assign nwe_s = nwe_sync[SYNC_STAGES-1];

    // Strobe synchronisers (idle-high) and plain re-registration of the bus.
    always_ff @(posedge clk) begin
        if (!sclr_n) begin
            ne_sync  <= '1;
            noe_sync <= '1;
            nwe_sync <= '1;
            a_r      <= '0;
            d_r      <= '0;
            nbl_r    <= '1;
        end else begin
            ne_sync  <= {ne_sync[SYNC_STAGES-2:0], bus.fsmc_ne};
            noe_sync <= {noe_sync[SYNC_STAGES-2:0], bus.fsmc_noe};
            nwe_sync <= {nwe_sync[SYNC_STAGES-2:0], bus.fsmc_nwe};
            a_r      <= bus.fsmc_a;
            d_r      <= bus.fsmc_d_in;
            nbl_r    <= bus.fsmc_nbl;
        end
    end

    // State register and all registered bus-side outputs.
    always_ff @(posedge clk) begin
        if (!sclr_n) begin
            state    <= IDLE;
            rdaddr_q <= '0;
            wraddr_q <= '0;
            wrdata_q <= '0;
            d_out_q  <= '0;
            be_q     <= '0;
            write_q  <= 1'b0;
            oe_q     <= 1'b0;
            err_q    <= 1'b0;
            rd_cnt_q <= '0;
`ifdef FSMC_TIMEOUT_EN
            tmo_cnt_q <= '0;
            ne_wait_q <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            rdaddr_q <= rdaddr_nxt;
            wraddr_q <= wraddr_nxt;
            wrdata_q <= wrdata_nxt;
            d_out_q  <= d_out_nxt;
            be_q     <= be_nxt;
            write_q  <= write_nxt;
            oe_q     <= oe_nxt;
            err_q    <= err_nxt;
            rd_cnt_q <= rd_cnt_nxt;
`ifdef FSMC_TIMEOUT_EN
            tmo_cnt_q <= tmo_cnt_nxt;
            ne_wait_q <= ne_wait_nxt;
`endif
        end
    end

    // Next-state and next-output decode.
    always_comb begin
        state_nxt  = state;
        rdaddr_nxt = rdaddr_q;
        wraddr_nxt = wraddr_q;
        wrdata_nxt = wrdata_q;
        d_out_nxt  = d_out_q;
        be_nxt     = be_q;
        write_nxt  = 1'b0;
        err_nxt    = err_q;
        rd_cnt_nxt = rd_cnt_q;
        oe_nxt     = ((state == RD_WAIT) || (state == RD_HOLD)) && !noe_s && !ne_s;
`ifdef FSMC_TIMEOUT_EN
        tmo_cnt_nxt = '0;
        ne_wait_nxt = ne_wait_q && !ne_s;
`endif

        case (state)
            IDLE: begin
                if (!noe_s && !nwe_s) begin
                    err_nxt = 1'b1;
                end else if (start_ok && !ne_s && !nwe_s) begin
                    state_nxt = WR_ACT;
                end else if (start_ok && !ne_s && !noe_s) begin
                    state_nxt  = RD_WAIT;
                    rdaddr_nxt = a_r;
                    rd_cnt_nxt = RCW'(RD_LAT);
                end
            end
            WR_ACT: begin
                // Capture only while the strobe is still seen low, so the
                // exit cycle never samples data from after the pad edge.
                if (nwe_s) begin
                    state_nxt = WR_COMMIT;
                end else if (ne_s) begin
                    state_nxt = IDLE;
                end else begin
                    wraddr_nxt = a_r;
                    wrdata_nxt = d_r;
                    be_nxt     = ~nbl_r;
                end
            end
            WR_COMMIT: begin
                write_nxt = 1'b1;
                state_nxt = IDLE;
            end
            RD_WAIT: begin
                if (rd_cnt_q == '0) begin
                    d_out_nxt = bus.rddata;
                    state_nxt = RD_HOLD;
                end else begin
                    rd_cnt_nxt = rd_cnt_q - RCW'(1);
                end
            end
            RD_HOLD: begin
                if (noe_s || ne_s) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

`ifdef FSMC_TIMEOUT_EN
        if ((state == WR_ACT) || (state == RD_WAIT) || (state == RD_HOLD)) begin
            if (tmo_cnt_q == 8'(TIMEOUT_CYCLES)) begin
                err_nxt     = 1'b1;
                oe_nxt      = 1'b0;
                write_nxt   = 1'b0;
                state_nxt   = IDLE;
                ne_wait_nxt = 1'b1;
            end else if (tmo_cnt_q != 8'hFF) begin
                tmo_cnt_nxt = tmo_cnt_q + 8'd1;
            end else begin
                tmo_cnt_nxt = tmo_cnt_q;
            end
        end
`endif
    end

    assign bus.rdaddr     = rdaddr_q;
    assign bus.wraddr     = wraddr_q;
    assign bus.wrdata     = wrdata_q;
    assign bus.be         = be_q;
    assign bus.write      = write_q;
    assign bus.fsmc_d_out = d_out_q;
    assign bus.fsmc_d_oe  = oe_q;
    assign busy           = (state != IDLE);
    assign err            = err_q;

endmodule

// File: tb/tb_fsmc_bridge.sv
// Scoreboard bench for fsmc_bridge: stimulus pushes expected write/read
// results, a negedge monitor pops and compares when the DUT presents them.
module tb_fsmc_bridge;

    logic clk = 1'b0;
    logic sclr_n = 1'b0;
    logic busy, err;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    fsmc_bridge_if bus();

    fsmc_bridge #(
        .SYNC_STAGES   (2),
        .RD_LAT        (2),
        .TIMEOUT_CYCLES(255)
    ) dut (
        .clk   (clk),
        .sclr_n(sclr_n),
        .bus   (bus.slave),
        .busy  (busy),
        .err   (err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] a;
        logic [15:0] d;
        logic [1:0]  be;
        int          cyc;
    } wr_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] d;
    } rd_t;

    wr_t wr_exp[$];
    rd_t rd_exp[$];

    // Register-bus model: two register stages from rdaddr to rddata.
    logic [15:0] sub_q = 16'h0000;
    logic [15:0] rddata_q = 16'h0000;
    assign bus.rddata = rddata_q;

    function automatic logic [15:0] reg_lookup(input logic [15:0] a);
        case (a)
            16'h0100: return 16'h1234;
            16'h0042: return 16'h5A18;
            16'hFFFF: return 16'hA5A5;
            default:  return 16'hDEAD;
        endcase
    endfunction

    always @(posedge clk) begin
        sub_q    <= reg_lookup(bus.rdaddr);
        rddata_q <= sub_q;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: pops expectations when a write pulse or end of a read appears.
    logic        prev_oe = 1'b0;
    logic [15:0] prev_dout = 16'h0000;
    always @(negedge clk) begin
        if (bus.write) begin
            if (wr_exp.size() == 0) begin
                n_checks++;
                $display("FAIL spurious_write: got write addr %0h data %0h expected none", bus.wraddr, bus.wrdata);
            end else begin
                wr_t e;
                e = wr_exp.pop_front();
                chk("write_fields", 64'({bus.wraddr, bus.wrdata, bus.be}), 64'({e.a, e.d, e.be}));
                chk("write_latency", 64'(cyc), 64'(e.cyc));
            end
        end
        if (prev_oe && !bus.fsmc_d_oe) begin
            if (rd_exp.size() == 0) begin
                n_checks++;
                $display("FAIL spurious_read: got oe pulse data %0h expected none", prev_dout);
            end else begin
                rd_t r;
                r = rd_exp.pop_front();
                chk("read_rdaddr", 64'(bus.rdaddr), 64'(r.a));
                chk("read_data", 64'(prev_dout), 64'(r.d));
            end
        end
        prev_oe   = bus.fsmc_d_oe;
        prev_dout = bus.fsmc_d_out;
    end

    task automatic do_write(input logic [15:0] a, input logic [15:0] d, input logic [1:0] nbl,
                            input logic [1:0] exp_be, input int low, input bit ne_first);
        wr_t e;
        bus.fsmc_a    = a;
        bus.fsmc_d_in = d;
        bus.fsmc_nbl  = nbl;
        bus.fsmc_ne   = 1'b0;
        bus.fsmc_nwe  = 1'b0;
        tick(4);
        chk("busy_in_write", 64'(busy), 64'(1));
        tick(low - 4);
        if (!ne_first) begin
            e.a = a; e.d = d; e.be = exp_be; e.cyc = cyc + 4;
            wr_exp.push_back(e);
            bus.fsmc_nwe = 1'b1;
            tick(2);
            bus.fsmc_ne = 1'b1;
        end else begin
            bus.fsmc_ne = 1'b1;
            tick(3);
            bus.fsmc_nwe = 1'b1;
        end
        tick(6);
    endtask

    task automatic do_read(input logic [15:0] a, input logic [15:0] exp_d);
        rd_t r;
        bus.fsmc_a  = a;
        bus.fsmc_ne = 1'b0;
        tick(1);
        r.a = a; r.d = exp_d;
        rd_exp.push_back(r);
        bus.fsmc_noe = 1'b0;
        tick(6);
        chk("read_dout_at_6", 64'({bus.fsmc_d_oe, bus.fsmc_d_out}), 64'({1'b1, exp_d}));
        tick(2);
        bus.fsmc_noe = 1'b1;
        tick(2);
        chk("oe_before_drop", 64'(bus.fsmc_d_oe), 64'(1));
        tick(1);
        chk("oe_after_drop", 64'(bus.fsmc_d_oe), 64'(0));
        bus.fsmc_ne = 1'b1;
        tick(4);
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, 64'({bus.wraddr, bus.wrdata, bus.be, bus.write, bus.fsmc_d_oe, busy, err}),
            64'(0));
        chk({name, "_rd"}, 64'({bus.rdaddr, bus.fsmc_d_out}), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        bus.fsmc_ne   = 1'b1;
        bus.fsmc_noe  = 1'b1;
        bus.fsmc_nwe  = 1'b1;
        bus.fsmc_nbl  = 2'b11;
        bus.fsmc_a    = 16'h0000;
        bus.fsmc_d_in = 16'h0000;
        sclr_n        = 1'b0;
        tick(3);
        chk_all_zero("reset_state");
        sclr_n = 1'b1;
        tick(3);

        do_write(16'h0184, 16'hA55A, 2'b00, 2'b11, 8, 1'b0);
        do_write(16'h0186, 16'h00C3, 2'b10, 2'b01, 6, 1'b0);
        do_write(16'h7FFE, 16'hFFFF, 2'b01, 2'b10, 4, 1'b0);
        do_write(16'h0200, 16'hBEEF, 2'b00, 2'b11, 6, 1'b1);

        do_read(16'h0100, 16'h1234);
        do_read(16'h0042, 16'h5A18);
        do_read(16'hFFFF, 16'hA5A5);

        // Protocol error: noe and nwe together.
        bus.fsmc_a   = 16'h0300;
        bus.fsmc_ne  = 1'b0;
        bus.fsmc_noe = 1'b0;
        bus.fsmc_nwe = 1'b0;
        tick(5);
        chk("proto_err", 64'({err, bus.fsmc_d_oe, busy}), 64'({1'b1, 1'b0, 1'b0}));
        bus.fsmc_ne  = 1'b1;
        bus.fsmc_noe = 1'b1;
        bus.fsmc_nwe = 1'b1;
        tick(4);
        chk("err_sticky", 64'(err), 64'(1));
        sclr_n = 1'b0;
        tick(1);
        sclr_n = 1'b1;
        tick(1);
        chk("err_cleared", 64'(err), 64'(0));
        tick(3);

        // Reset in the middle of a write.
        bus.fsmc_a    = 16'h0310;
        bus.fsmc_d_in = 16'h1111;
        bus.fsmc_nbl  = 2'b00;
        bus.fsmc_ne   = 1'b0;
        bus.fsmc_nwe  = 1'b0;
        tick(5);
        chk("busy_before_reset", 64'(busy), 64'(1));
        sclr_n = 1'b0;
        tick(1);
        chk_all_zero("reset_mid_write");
        bus.fsmc_ne  = 1'b1;
        bus.fsmc_nwe = 1'b1;
        tick(3);
        sclr_n = 1'b1;
        tick(6);

        do_write(16'h0020, 16'h5AA5, 2'b00, 2'b11, 5, 1'b0);
        do_read(16'h0100, 16'h1234);

`ifdef FSMC_TIMEOUT_EN
        begin
            rd_t r;
            r.a = 16'h0042; r.d = 16'h5A18;
            rd_exp.push_back(r);
            bus.fsmc_a   = 16'h0042;
            bus.fsmc_ne  = 1'b0;
            bus.fsmc_noe = 1'b0;
            tick(280);
            chk("timeout_err", 64'({err, bus.fsmc_d_oe, busy}), 64'({1'b1, 1'b0, 1'b0}));
            tick(20);
            chk("timeout_no_restart", 64'(busy), 64'(0));
            bus.fsmc_ne  = 1'b1;
            bus.fsmc_noe = 1'b1;
            tick(5);
            do_read(16'hFFFF, 16'hA5A5);
        end
`endif

        tick(5);
        chk("wr_queue_empty", 64'(wr_exp.size()), 64'(0));
        chk("rd_queue_empty", 64'(rd_exp.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
